// File: rtl/lcd_write_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_write_sequencer
//
// Generates HD44780-style write cycles (setup, enable pulse, hold, busy wait)
// on a write-only character LCD bus and shares that bus round-robin between
// two requesters. Clear (0x01) and home (0x02) commands get the long busy
// wait; every other write gets the short one.
//
// Optional feature macro: LCD_INIT_EN
//   When defined, reset enters a power-up delay and then issues the LCD init
//   command string (0x38, 0x38, 0x38, 0x0C, 0x01, 0x06) before accepting any
//   requester. When undefined, reset goes straight to IDLE.
//
// Ports:
//   clkin_50          system clock (50 MHz)
//   rst               synchronous reset, active-high
//   a_req/a_rs/a_data port A request (level, held until a_ack), reg select, byte
//   a_ack             one-cycle pulse on the last busy-wait cycle of A's write
//   b_req/b_rs/b_data port B, same as port A
//   b_ack             one-cycle pulse on the last busy-wait cycle of B's write
//   busy              high whenever the sequencer is not idle
//   lcd_d_out         LCD data bus value
//   lcd_en            LCD enable strobe
//   lcd_rw            LCD read/write, tied to write (0)
//   lcd_rs            LCD register select
// ---------------------------------------------------------------------------
module lcd_write_sequencer #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_CYC         = 12,
  parameter int HOLD_CYC       = 2,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int POWERUP_CYC    = 750000
) (
  input  logic       clkin_50,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_rs,
  input  logic [7:0] a_data,
  output logic       a_ack,
  input  logic       b_req,
  input  logic       b_rs,
  input  logic [7:0] b_data,
  output logic       b_ack,
  output logic       busy,
  output logic [7:0] lcd_d_out,
  output logic       lcd_en,
  output logic       lcd_rw,
  output logic       lcd_rs
);

  // Counter load values: each timed state lasts N cycles, counting N-1 .. 0.
  localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EN_LD    = 20'(EN_CYC - 1);
  localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC - 1);
  localparam logic [19:0] SHORT_LD = 20'(SHORT_WAIT_CYC - 1);
  localparam logic [19:0] LONG_LD  = 20'(LONG_WAIT_CYC - 1);
`ifdef LCD_INIT_EN
  localparam logic [19:0] PWR_LD   = 20'(POWERUP_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_WAIT, S_INIT_PWR, S_INIT_CMD
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] wait_ld_q, wait_ld_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        last_b_q, last_b_d;  // 1: port B was granted most recently
  logic        gnt_b_q, gnt_b_d;    // port owning the write in flight

  logic        cnt_zero;
  logic        grant, pick_b, sel_rs, ack_fire, init_phase;
  logic [7:0]  sel_data;

  // Clear and home need the long busy wait.
  function automatic logic [19:0] wait_load(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? LONG_LD : SHORT_LD;
  endfunction

`ifdef LCD_INIT_EN
  logic       in_init_q, in_init_d;
  logic [2:0] idx_q, idx_d;

  function automatic logic [7:0] init_cmd(input logic [2:0] i);
    case (i)
      3'd3:    return 8'h0C;
      3'd4:    return 8'h01;
      3'd5:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

  assign init_phase = in_init_q;
`else
  assign init_phase = 1'b0;
`endif

  assign cnt_zero = (cnt_q == '0);

  // Round-robin: on a tie the port not granted last wins.
  assign grant    = a_req | b_req;
  assign pick_b   = b_req & (~a_req | ~last_b_q);
  assign sel_rs   = pick_b ? b_rs : a_rs;
  assign sel_data = pick_b ? b_data : a_data;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - 20'd1;
    wait_ld_d = wait_ld_q;
    rs_d      = rs_q;
    data_d    = data_q;
    last_b_d  = last_b_q;
    gnt_b_d   = gnt_b_q;
`ifdef LCD_INIT_EN
    in_init_d = in_init_q;
    idx_d     = idx_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d   = S_SETUP;
          cnt_d     = SETUP_LD;
          rs_d      = sel_rs;
          data_d    = sel_data;
          wait_ld_d = wait_load(sel_rs, sel_data);
          gnt_b_d   = pick_b;
          last_b_d  = pick_b;
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_d = S_ENABLE;
          cnt_d   = EN_LD;
        end
      end
      S_ENABLE: begin
        if (cnt_zero) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt_zero) begin
          state_d = S_WAIT;
          cnt_d   = wait_ld_q;
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
`ifdef LCD_INIT_EN
          if (in_init_q && idx_q != 3'd6) begin
            state_d = S_INIT_CMD;
          end else begin
            state_d   = S_IDLE;
            in_init_d = 1'b0;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef LCD_INIT_EN
      S_INIT_PWR: begin
        if (cnt_zero) state_d = S_INIT_CMD;
      end
      S_INIT_CMD: begin
        state_d   = S_SETUP;
        cnt_d     = SETUP_LD;
        rs_d      = 1'b0;
        data_d    = init_cmd(idx_q);
        wait_ld_d = wait_load(1'b0, init_cmd(idx_q));
        idx_d     = idx_q + 3'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    en_d     = (state_d == S_ENABLE);
    busy_d   = (state_d != S_IDLE);
    ack_fire = (state_d == S_WAIT) && (cnt_d == '0) && !init_phase;
    a_ack_d  = ack_fire && !gnt_b_d;
    b_ack_d  = ack_fire && gnt_b_d;
  end

  always_ff @(posedge clkin_50) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values and the update order does not matter.
    if (rst) begin
      wait_ld_q <= '0;
      rs_q      <= 1'b0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      last_b_q  <= 1'b1;
      gnt_b_q   <= 1'b0;
`ifdef LCD_INIT_EN
      state_q   <= S_INIT_PWR;
      cnt_q     <= PWR_LD;
      busy_q    <= 1'b1;
      in_init_q <= 1'b1;
      idx_q     <= 3'd0;
`else
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_ld_q <= wait_ld_d;
      rs_q      <= rs_d;
      data_q    <= data_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      last_b_q  <= last_b_d;
      gnt_b_q   <= gnt_b_d;
`ifdef LCD_INIT_EN
      in_init_q <= in_init_d;
      idx_q     <= idx_d;
`endif
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign busy      = busy_q;
  assign lcd_d_out = data_q;
  assign lcd_en    = en_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = 1'b0;

endmodule
